// File: rtl/reg_bank_writer.sv
// Write side of a 4 x WIDTH register bank: 2-entry request FIFO, one byte-masked commit per cycle.
// Optional feature macro: REG_BANK_ZERO_REG_EN (register 0 hardwired to zero).
module reg_bank_writer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [1:0]         wr_reg_no,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               commit_hold,
  output logic [WIDTH-1:0]   q0,
  output logic [WIDTH-1:0]   q1,
  output logic [WIDTH-1:0]   q2,
  output logic [WIDTH-1:0]   q3,
  output logic [3:0]         pending,
  output logic               busy
);

  localparam int unsigned NBYTES = WIDTH / 8;
`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_push;
  logic               w_pop;
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_mem_reg  [2];
  logic [WIDTH-1:0]   r_mem_data [2];
  logic [NBYTES-1:0]  r_mem_be   [2];
  logic [WIDTH-1:0]   r_q        [4];
  logic [3:0]         w_we;
  logic [1:0]         w_ent_valid;

  assign wr_ready = (r_state != S_FULL);
  assign busy     = (r_state != S_EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Occupancy FSM: simultaneous push and pop leaves the state unchanged.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = wr_valid && (r_state != S_FULL);
    w_pop       = (r_state != S_EMPTY) && !commit_hold;
    case (r_state)
      S_EMPTY: if (w_push) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_FULL;
        else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_mem_reg[i]  <= '0;
        r_mem_data[i] <= '0;
        r_mem_be[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_reg[r_wptr]  <= wr_reg_no;
        r_mem_data[r_wptr] <= wr_data;
        r_mem_be[r_wptr]   <= wr_be;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  // One-hot target decode for the head entry, gated by the pop.
  always_comb begin
    w_we = 4'b0000;
    if (w_pop) begin
      case (r_mem_reg[r_rptr])
        2'd0:    w_we = 4'b0001;
        2'd1:    w_we = 4'b0010;
        2'd2:    w_we = 4'b0100;
        default: w_we = 4'b1000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) r_q[r] <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (w_we[r] && !(ZERO_REG && r == 0)) begin
          for (int b = 0; b < int'(NBYTES); b++) begin
            if (r_mem_be[r_rptr][b]) r_q[r][8*b +: 8] <= r_mem_data[r_rptr][8*b +: 8];
          end
        end
      end
    end
  end

  // Entry i is live when the buffer is full, or it is the head of a one-entry buffer.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_ent_valid[i] = (r_state == S_FULL) || ((r_state == S_ONE) && (r_rptr == 1'(i)));
    end
  end

  always_comb begin
    pending = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (w_ent_valid[i] && (r_mem_reg[i] == 2'(r))) pending[r] = 1'b1;
      end
    end
    if (ZERO_REG) pending[0] = 1'b0;
  end

  assign q0 = r_q[0];
  assign q1 = r_q[1];
  assign q2 = r_q[2];
  assign q3 = r_q[3];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: directed vector table, reset corner case, random traffic vs. a queue model.
// Honours REG_BANK_ZERO_REG_EN when the design is built with it.
module tb_reg_bank_writer;

`ifdef REG_BANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_reg_no;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        commit_hold;
  logic [31:0] q0, q1, q2, q3;
  logic [3:0]  pending;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_bank_writer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_reg_no(wr_reg_no), .wr_data(wr_data), .wr_be(wr_be),
    .commit_hold(commit_hold), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .pending(pending), .busy(busy)
  );

  typedef struct {
    logic [1:0]  rn;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic        v;
    logic        h;
    logic [1:0]  rn;
    logic [31:0] d;
    logic [3:0]  be;
    logic        exp_ready;
    logic [3:0]  exp_pend;
    logic        exp_busy;
    logic [1:0]  chk_reg;
    logic [31:0] exp_val;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] m_q [4];

  function automatic vec_t mk(logic v, logic h, logic [1:0] rn, logic [31:0] d, logic [3:0] be,
                              logic er, logic [3:0] ep, logic eb, logic [1:0] cr, logic [31:0] ev);
    vec_t t;
    t.v = v; t.h = h; t.rn = rn; t.d = d; t.be = be;
    t.exp_ready = er; t.exp_pend = ep; t.exp_busy = eb; t.chk_reg = cr; t.exp_val = ev;
    return t;
  endfunction

  function automatic logic [31:0] dut_q(logic [1:0] r);
    case (r)
      2'd0:    return q0;
      2'd1:    return q1;
      2'd2:    return q2;
      default: return q3;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_pending();
    logic [3:0] p = 4'b0000;
    foreach (mq[i]) if (!(ZR && mq[i].rn == 2'd0)) p[mq[i].rn] = 1'b1;
    return p;
  endfunction

  task automatic compare_all(string tag);
    chk({tag, ".ready"},   32'(wr_ready), 32'(mq.size() != 2));
    chk({tag, ".busy"},    32'(busy),     32'(mq.size() != 0));
    chk({tag, ".pending"}, 32'(pending),  32'(model_pending()));
    for (int r = 0; r < 4; r++) chk($sformatf("%s.q%0d", tag, r), dut_q(2'(r)), m_q[r]);
  endtask

  // Drive one cycle from a negedge, advance the model across the posedge, compare at the next negedge.
  task automatic step(logic v, logic h, logic [1:0] rn, logic [31:0] d, logic [3:0] be, string tag);
    bit   acc, pop;
    ent_t e;
    wr_valid = v; commit_hold = h; wr_reg_no = rn; wr_data = d; wr_be = be;
    acc = v && (mq.size() != 2);
    pop = (mq.size() != 0) && !h;
    @(posedge clk);
    if (pop) begin
      e = mq.pop_front();
      if (!(ZR && e.rn == 2'd0))
        for (int b = 0; b < 4; b++) if (e.be[b]) m_q[e.rn][8*b +: 8] = e.d[8*b +: 8];
    end
    if (acc) begin
      e.rn = rn; e.d = d; e.be = be;
      mq.push_back(e);
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 4; r++) m_q[r] = '0;
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(1, 0, 2, 32'hDEADBEEF, 4'hF, 1, 4'b0100, 1, 2, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 4'b0000, 0, 2, 32'hDEADBEEF);
    tbl[2]  = mk(1, 0, 1, 32'h11223344, 4'hF, 1, 4'b0010, 1, 1, 32'h0);
    tbl[3]  = mk(1, 0, 1, 32'hAABBCCDD, 4'h5, 1, 4'b0010, 1, 1, 32'h11223344);
    tbl[4]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 4'b0000, 0, 1, 32'h11BB33DD);
    tbl[5]  = mk(1, 1, 3, 32'h1,        4'hF, 1, 4'b1000, 1, 3, 32'h0);
    tbl[6]  = mk(1, 1, 3, 32'h2,        4'hF, 0, 4'b1000, 1, 3, 32'h0);
    tbl[7]  = mk(1, 1, 3, 32'h3,        4'hF, 0, 4'b1000, 1, 3, 32'h0);
    tbl[8]  = mk(1, 0, 3, 32'h3,        4'hF, 1, 4'b1000, 1, 3, 32'h1);
    tbl[9]  = mk(1, 0, 3, 32'h3,        4'hF, 1, 4'b1000, 1, 3, 32'h2);
    tbl[10] = mk(0, 0, 0, 32'h0,        4'h0, 1, 4'b0000, 0, 3, 32'h3);
    tbl[11] = mk(1, 0, 0, 32'hFFFFFFFF, 4'hF, 1, ZR ? 4'b0000 : 4'b0001, 1, 0, 32'h0);
    tbl[12] = mk(1, 0, 1, 32'hB1B1B1B1, 4'hF, 1, 4'b0010, 1, 0, ZR ? 32'h0 : 32'hFFFFFFFF);
    tbl[13] = mk(1, 0, 2, 32'hC2C2C2C2, 4'hF, 1, 4'b0100, 1, 1, 32'hB1B1B1B1);
    tbl[14] = mk(1, 0, 3, 32'hD3D3D3D3, 4'hF, 1, 4'b1000, 1, 2, 32'hC2C2C2C2);
    tbl[15] = mk(0, 0, 0, 32'h0,        4'h0, 1, 4'b0000, 0, 3, 32'hD3D3D3D3);
    tbl[16] = mk(1, 0, 3, 32'hFFFFFFFF, 4'h0, 1, 4'b1000, 1, 3, 32'hD3D3D3D3);
    tbl[17] = mk(0, 0, 0, 32'h0,        4'h0, 1, 4'b0000, 0, 3, 32'hD3D3D3D3);

    reset = 1'b1; wr_valid = 1'b0; commit_hold = 1'b0;
    wr_reg_no = '0; wr_data = '0; wr_be = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].v, tbl[k].h, tbl[k].rn, tbl[k].d, tbl[k].be, $sformatf("row%0d", k));
      chk($sformatf("row%0d.tbl_ready", k), 32'(wr_ready), 32'(tbl[k].exp_ready));
      chk($sformatf("row%0d.tbl_pending", k), 32'(pending), 32'(tbl[k].exp_pend));
      chk($sformatf("row%0d.tbl_busy", k), 32'(busy), 32'(tbl[k].exp_busy));
      chk($sformatf("row%0d.tbl_q", k), dut_q(tbl[k].chk_reg), tbl[k].exp_val);
    end

    // Fill the buffer under hold, then reset asynchronously mid-cycle.
    step(1, 1, 1, 32'h12345678, 4'hF, "fill0");
    step(1, 1, 2, 32'h9ABCDEF0, 4'hF, "fill1");
    chk("full.ready", 32'(wr_ready), 32'h0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_reset");
    chk("async_reset.q1", q1, 32'h0);
    chk("async_reset.busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0, 4'h0, "post_reset");
    chk("post_reset.q1", q1, 32'h0);
    chk("post_reset.q2", q2, 32'h0);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
           2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), "rand");
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0, 4'h0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
